// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end. Owns the PC, addresses the
// instruction memory, captures the same-cycle read data and queues
// {pc, inst} pairs in a DEPTH-entry FIFO drained by decode (valid/ready).
// A redirect flushes the FIFO and reloads the PC.
// Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect target raises
// fetch_fault and halts fetch until an aligned redirect or reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_target,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst_data,
  output logic [31:0]                inst_pc,
  output logic [$clog2(DEPTH):0]     buf_count
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                       fetch_fault
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic [31:0]     pc;
  logic            halted;
  logic            pop, push;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault;
  assign halted      = fault;
  assign fetch_fault = fault;
`else
  assign halted = 1'b0;
`endif

  assign imem_addr  = pc;
  assign inst_valid = (count != '0);
  assign buf_count  = count;
  assign inst_data  = inst_valid ? mem[head].inst : 32'h0;
  assign inst_pc    = inst_valid ? mem[head].pc   : 32'h0;

  // A full buffer can still take a new word when the head leaves this cycle.
  assign pop  = inst_valid & inst_ready;
  assign push = ~rst & ~redirect_valid & ~halted & ((count < CW'(DEPTH)) | pop);

  // Buffer storage: entries are only observed while counted, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{pc: pc, inst: imem_rdata};
  end

  // PC, pointers and occupancy; reset beats redirect beats normal flow.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault <= 1'b0;
`endif
    end else if (redirect_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_target[1:0] != 2'b00) begin
        fault <= 1'b1;
        pc    <= redirect_target;
      end else begin
        fault <= 1'b0;
        pc    <= redirect_target;
      end
`else
      pc <= {redirect_target[31:2], 2'b00};
`endif
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
        pc   <= pc + 32'd4;
      end
      if (pop) head <= head + 1'b1;
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the instruction memory.
- Owns the program counter, drives the memory word address, and captures the combinational read data returned in the same cycle.
- Buffers fetched {pc, instruction} pairs in a small FIFO that the decode stage drains through a valid/ready handshake.
- Handles control-flow redirects (branch/jump) by flushing the buffer and reloading the PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, instruction buffer entries; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- imem_addr  output  32  byte address to instruction memory; always equals the current PC.
- imem_rdata  input  32  instruction word returned combinationally for imem_addr.
- redirect_valid  input  1  control-flow change request.
- redirect_target  input  32  new PC when redirect_valid=1.
- inst_valid  output  1  buffer head holds a valid instruction.
- inst_ready  input  1  decode accepts the head this cycle.
- inst_data  output  32  instruction at buffer head.
- inst_pc  output  32  PC of the instruction at buffer head.
- buf_count  output  $clog2(DEPTH)+1  current buffer occupancy.

Behaviour:
- Reset (rst=1 at edge):
  - pc <= RESET_PC; buffer emptied; buf_count=0; inst_valid=0.
  - inst_data and inst_pc read 0 while the buffer is empty.
- Outputs are registered-state driven:
  - imem_addr = pc.
  - inst_valid = (count != 0).
  - inst_data and inst_pc come from the head entry.
- pop = inst_valid & inst_ready.
- push = ~rst & ~redirect_valid & (count < DEPTH | pop).
  - A full buffer accepts a push in the same cycle it pops.
- On push:
  - Write {pc, imem_rdata} at the tail.
  - pc <= pc + 4, modulo 2^32: 32'hFFFF_FFFC wraps to 0.
  - Fetch latency is 1 cycle: the word addressed in cycle N is visible at the head in cycle N+1 if the buffer was empty.
- No push: pc holds.
- Count update:
  - count <= count + push - pop.
  - Head and tail pointers wrap modulo DEPTH.
- Redirect (redirect_valid=1):
  - Highest priority after rst: the buffer is flushed (count <= 0, pointers reset).
  - No push that cycle.
  - pc <= {redirect_target[31:2], 2'b00}, unless overridden by the optional feature.
  - A pop in the same cycle is still a handshake; decode has consumed the old head, but the entry is discarded regardless.
  - The first post-redirect instruction appears at the head 1 cycle after the redirect edge.
- Back-pressure: with inst_ready held low, the buffer fills to DEPTH and pc stalls at the address of the next unfetched word. No instruction is lost or duplicated.
- Reset during any operation, including a simultaneous redirect or a full buffer: rst wins and all state returns to reset values.
- Ordering: inst_pc values leave the buffer strictly in fetch order, each 4 above the previous, except across a redirect.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- When defined:
  - Adds output fetch_fault (1 bit), reset 0.
  - A redirect with redirect_target[1:0] != 0 sets fetch_fault=1, loads pc with the unmodified target, flushes the buffer, and blocks all pushes.
  - The block stays halted until the next redirect with an aligned target, which clears fetch_fault and resumes normal operation, or until rst.
- When undefined: no fetch_fault port; target bits [1:0] are silently forced to 0.

Test Plan:
- Reset, then free-run with inst_ready=1 and memory word k = 32'h1000_0000+k → inst_valid rises 1 cycle after reset release; inst_pc = 0, 4, 8, … with inst_data = 32'h1000_0000, 32'h1000_0001, … on consecutive cycles.
- inst_ready=0 for 5 cycles after reset → buf_count reaches 2 and holds; imem_addr freezes at 8. Then inst_ready=1 → outputs pc 0, 4, 8 in order with no gap or duplicate.
- Redirect to 32'h0000_0100 while the buffer holds 2 entries → next cycle buf_count=0 and imem_addr=0x100; one cycle later inst_pc=0x100 at the head.
- Buffer full, inst_ready=1 held → pop and push every cycle; buf_count stays 2 and throughput is 1 instruction per cycle.
- RESET_PC=32'hFFFF_FFF8 with free-run → inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- FETCH_MISALIGN_TRAP_EN defined, redirect to 0x102 → fetch_fault=1, inst_valid stays 0. Then redirect to 0x200 → fetch_fault=0 and fetch resumes at 0x200. With the macro undefined, the same redirect to 0x102 fetches from 0x100.
